alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001: Parameter XLEN, default 32; operand and result width, power of two, 8 to 64.
REQ-002: Parameter SHW, default $clog2(XLEN); shift-amount width.
REQ-003: clk  input  1  sole clock, rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: flush  input  1  abort any operation in flight.
REQ-006: in_valid  input  1  request present.
REQ-007: in_ready  output  1  request accepted on an edge where in_valid && in_ready && !flush.
REQ-008: alu_op  input  5  operation code (package encoding).
REQ-009: src_op1  input  XLEN  first operand, unsigned bit vector.
REQ-010: src_op2  input  XLEN  second operand or shift amount (bits [SHW-1:0]).
REQ-011: out_valid  output  1  result held on alu_out.
REQ-012: out_ready  input  1  result consumed on an edge where out_valid && out_ready.
REQ-013: alu_out  output  XLEN  registered result.
REQ-014: busy  output  1  high in MUL or DIV state.

Function
REQ-015: States IDLE, MUL, DIV, DONE; one request in flight at most.
REQ-016: in_ready = (state==IDLE) || (state==DONE && out_ready); combinational, no dependence on in_valid.
REQ-017: Base ops ADD, SUB, SLT, SLTU, SGE, SGEU, AND, OR, XOR, SEQ, SNE, SL, SR, SRA: result registered at accept edge, state -> DONE, latency 1 edge.
REQ-018: Compare ops return 1 or 0 zero-extended to XLEN; SLT/SGE signed, SLTU/SGEU unsigned.
REQ-019: SL/SR/SRA shift by src_op2[SHW-1:0] only; SRA replicates src_op1[XLEN-1].
REQ-020: MUL, MULH, MULHSU, MULHU: operands latched at accept, state -> MUL, radix-2 shift-add, one iteration per edge, XLEN iterations, then DONE; latency XLEN+1 edges.
REQ-021: MUL returns low XLEN bits of product; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, upper XLEN bits of 2*XLEN product.
REQ-022: DIV, DIVU, REM, REMU: state -> DIV, restoring division on magnitudes, XLEN iterations, sign fix-up in the final iteration; latency XLEN+1 edges.
REQ-023: Divide by zero: DIV/DIVU quotient all ones, REM/REMU remainder = src_op1; same latency as normal divide.
REQ-024: Signed overflow (src_op1 = most-negative, src_op2 = -1): DIV returns most-negative, REM returns 0.
REQ-025: Remainder sign follows dividend; quotient truncates toward zero.
REQ-026: DONE holds alu_out and out_valid stable until out_ready; DONE && out_ready && in_valid accepts the next request on the same edge (back-to-back).
REQ-027: DONE && out_ready && !in_valid -> IDLE, out_valid low next cycle.
REQ-028: flush: next state IDLE, out_valid low next cycle, in-flight result discarded, no request accepted on a flush edge; flush takes priority over in_valid and out_ready.
REQ-029: Undefined alu_op codes execute as ADD.
REQ-030: alu_out is the last result when out_valid is low; no X propagation from idle datapath.

Reset
REQ-031: rst on a rising edge: state IDLE, out_valid 0, alu_out 0, busy 0, iteration counter 0; in_ready 1 in the cycle after.
REQ-032: rst asserted mid-MUL/DIV or in DONE discards the operation; rst overrides flush and all handshakes.

Structure
REQ-033: Package alu_pkg holds the 5-bit ALU_* op encodings, the state enumeration and the op-class decode function (base/mul/div).
REQ-034: One sub-module alu_base: combinational, XLEN-parametrised, implements REQ-017..REQ-019; iterative mul/div, FSM and handshake stay in alu_muldiv.

Verification
REQ-035: XLEN=32, ADD 0xFFFFFFFF + 1, out_ready=1 -> out_valid one edge later, alu_out 0x00000000; SRA 0x80000000 by 0x24 -> 0xF8000000 (shamt 4).
REQ-036: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 after 33 edges; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
REQ-037: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7; DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-038: out_ready held low 5 cycles in DONE -> alu_out stable, in_ready 0; then out_ready=1 with in_valid=1 -> next op accepted same edge.
REQ-039: flush at iteration 10 of DIVU -> out_valid never rises for it, in_ready 1 next cycle, following ADD 2+3 returns 5.
REQ-040: rst during MUL iteration 20 -> out_valid 0, busy 0 next cycle; XLEN=8 build repeats REQ-036 with 0xFF operands, latency 9 edges.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit.
//   - ALU_* : 5-bit operation encodings driven on alu_op
//   - ST_*  : controller state encodings
//   - op_class() : sorts an opcode into base / multiply / divide handling
package alu_pkg;

  // Single-cycle operations
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLT    = 5'd2;
  localparam logic [4:0] ALU_SLTU   = 5'd3;
  localparam logic [4:0] ALU_SGE    = 5'd4;
  localparam logic [4:0] ALU_SGEU   = 5'd5;
  localparam logic [4:0] ALU_AND    = 5'd6;
  localparam logic [4:0] ALU_OR     = 5'd7;
  localparam logic [4:0] ALU_XOR    = 5'd8;
  localparam logic [4:0] ALU_SEQ    = 5'd9;
  localparam logic [4:0] ALU_SNE    = 5'd10;
  localparam logic [4:0] ALU_SL     = 5'd11;
  localparam logic [4:0] ALU_SR     = 5'd12;
  localparam logic [4:0] ALU_SRA    = 5'd13;
  // Iterative multiply
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  // Iterative divide
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    OPC_BASE,
    OPC_MUL,
    OPC_DIV
  } op_class_e;

  // Anything that is not a multiply or divide is handled by the base ALU,
  // which is also where undefined codes end up (executed as ADD).
  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return OPC_MUL;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:     return OPC_DIV;
      default:                                  return OPC_BASE;
    endcase
  endfunction

endpackage

// File: rtl/alu_base.sv
// Combinational single-cycle ALU: add/sub, compares, logic ops and shifts.
// Ports:
//   alu_op   - operation code (alu_pkg encoding); undefined codes act as ADD
//   src_op1  - first operand
//   src_op2  - second operand; shifts use only bits [SHW-1:0]
//   result   - operation result, compares zero-extended to XLEN
module alu_base
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src_op1,
  input  logic [XLEN-1:0] src_op2,
  output logic [XLEN-1:0] result
);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = src_op2[SHW-1:0];
  assign lt_s  = $signed(src_op1) < $signed(src_op2);
  assign lt_u  = src_op1 < src_op2;

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred; it also makes undefined opcodes behave as ADD.
    result = src_op1 + src_op2;
    case (alu_op)
      ALU_SUB:  result = src_op1 - src_op2;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SGE:  result = {{(XLEN-1){1'b0}}, !lt_s};
      ALU_SGEU: result = {{(XLEN-1){1'b0}}, !lt_u};
      ALU_AND:  result = src_op1 & src_op2;
      ALU_OR:   result = src_op1 | src_op2;
      ALU_XOR:  result = src_op1 ^ src_op2;
      ALU_SEQ:  result = {{(XLEN-1){1'b0}}, src_op1 == src_op2};
      ALU_SNE:  result = {{(XLEN-1){1'b0}}, src_op1 != src_op2};
      ALU_SL:   result = src_op1 << shamt;
      ALU_SR:   result = src_op1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(src_op1) >>> shamt);
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with iterative multiply (radix-2 shift-add) and divide (restoring),
// valid/ready handshake on both sides, one request in flight.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - abort whatever is in flight, no accept on that edge
//   in_valid/ready  - request handshake; alu_op, src_op1, src_op2 payload
//   out_valid/ready - result handshake; alu_out holds the registered result
//   busy            - multiply or divide iterating
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src_op1,
  input  logic [XLEN-1:0] src_op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  logic [1:0]      state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] base_res;
  logic            accept;
  logic            last_iter;

  // Iteration datapath, shared by multiply and divide:
  //   multiply: acc_hi = partial product, acc_lo = multiplier, opnd = multiplicand
  //   divide:   acc_hi = remainder,       acc_lo = dividend/quotient, opnd = divisor
  logic [XLEN-1:0] acc_hi, acc_lo, opnd;
  logic [4:0]      op_q;
  logic            neg_res;   // negate product or quotient at the end
  logic            neg_rem;   // negate remainder (follows dividend sign)
  logic            div_zero;

  logic            op1_neg, op2_neg;
  logic [XLEN-1:0] op1_mag, op2_mag;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_hi_nxt, div_lo_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  alu_base #(.XLEN(XLEN), .SHW(SHW)) u_base (
    .alu_op  (alu_op),
    .src_op1 (src_op1),
    .src_op2 (src_op2),
    .result  (base_res)
  );

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MUL) || (state == ST_DIV);
  assign last_iter = (cnt == SHW'(XLEN-1));

  // Signed ops iterate on magnitudes; the sign is restored on the last step.
  assign op1_neg = src_op1[XLEN-1] &&
                   (alu_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
  assign op2_neg = src_op2[XLEN-1] && (alu_op inside {ALU_MULH, ALU_DIV, ALU_REM});
  assign op1_mag = op1_neg ? -src_op1 : src_op1;
  assign op2_mag = op2_neg ? -src_op2 : src_op2;

  // One shift-add step: add multiplicand if multiplier LSB set, shift right.
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nxt = mul_sum[XLEN:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};

  // One restoring step. The remainder stays below the divisor, so the top
  // bit of the difference is a clean borrow; with a zero divisor the shifted
  // value never reaches bit XLEN and every step succeeds (quotient all ones).
  assign div_shift  = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, opnd};
  assign div_ge     = !div_diff[XLEN];
  assign div_hi_nxt = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_nxt = {acc_lo[XLEN-2:0], div_ge};

  // Sign fix-up folded into the final iteration. A zero divisor leaves the
  // remainder equal to the dividend after the fix-up, so only the quotient
  // needs forcing.
  assign prod_fix = neg_res ? -{mul_hi_nxt, mul_lo_nxt} : {mul_hi_nxt, mul_lo_nxt};
  assign quo_fix  = div_zero ? '1 : (neg_res ? -div_lo_nxt : div_lo_nxt);
  assign rem_fix  = neg_rem ? -div_hi_nxt : div_hi_nxt;

  always_comb begin
    final_res = rem_fix;
    if (state == ST_MUL)
      final_res = (op_q == ALU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (op_q == ALU_DIV || op_q == ALU_DIVU)
      final_res = quo_fix;
  end

  // Control: state, iteration count and the visible result.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      alu_out <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            case (op_class(alu_op))
              OPC_MUL: state <= ST_MUL;
              OPC_DIV: state <= ST_DIV;
              default: begin
                alu_out <= base_res;
                state   <= ST_DONE;
              end
            endcase
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (last_iter) begin
            cnt     <= '0;
            alu_out <= final_res;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: the iteration registers carry no reset; they are always loaded on
  // the accept edge before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_hi   <= '0;
      acc_lo   <= op1_mag;
      opnd     <= op2_mag;
      op_q     <= alu_op;
      neg_res  <= op1_neg ^ op2_neg;
      neg_rem  <= op1_neg;
      div_zero <= (src_op2 == '0);
    end else if (state == ST_MUL) begin
      acc_hi <= mul_hi_nxt;
      acc_lo <= mul_lo_nxt;
    end else if (state == ST_DIV) begin
      acc_hi <= div_hi_nxt;
      acc_lo <= div_lo_nxt;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus random
// operations compared against an arithmetic reference model. A second
// XLEN=8 instance covers the narrow build.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready, out_valid, busy;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] src_op1, src_op2, alu_out;

  logic       flush8, in_valid8, out_ready8, in_ready8, out_valid8, busy8;
  logic [4:0] alu_op8;
  logic [7:0] a8, b8, alu_out8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_op1(src_op1), .src_op2(src_op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .busy(busy)
  );

  alu_muldiv #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op8), .src_op1(a8), .src_op2(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .alu_out(alu_out8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions.
  function automatic logic [31:0] ref_model(input logic [4:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    case (op)
      ALU_SUB:    return a - b;
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_SGE:    return (sa >= sb) ? 32'd1 : 32'd0;
      ALU_SGEU:   return (a >= b) ? 32'd1 : 32'd0;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SEQ:    return (a == b) ? 32'd1 : 32'd0;
      ALU_SNE:    return (a != b) ? 32'd1 : 32'd0;
      ALU_SL:     return a << b[4:0];
      ALU_SR:     return a >> b[4:0];
      ALU_SRA:    begin p = sa >>> b[4:0]; return p[31:0]; end
      ALU_MUL:    begin p = ua * ub; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      ALU_REMU:   return (b == 0) ? a : a % b;
      default:    return a + b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] op);
    if (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                   ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU})
      return XLEN + 1;
    return 1;
  endfunction

  // Consume a held result and confirm the unit returns to idle.
  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/drained"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  // Issue one request from idle, measure latency, compare, then drain.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    string tag;
    int    edges;
    tag = $sformatf("op%0d a=%08h b=%08h", op, a, b);
    @(negedge clk);
    alu_op = op; src_op1 = a; src_op2 = b;
    in_valid = 1'b1; out_ready = 1'b0;
    #1 check({tag, "/in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "/latency"}, 64'(edges), 64'(exp_latency(op)));
    check({tag, "/result"}, alu_out, ref_model(op, a, b));
    drain(tag);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_pool [26] = '{
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SGE, ALU_SGEU, ALU_AND, ALU_OR,
    ALU_XOR, ALU_SEQ, ALU_SNE, ALU_SL, ALU_SR, ALU_SRA, ALU_MUL, ALU_MULH,
    ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    5'd14, 5'd15, 5'd24, 5'd31
  };

  logic [4:0] ops8 [3] = '{ALU_MULH, ALU_MULHU, ALU_MUL};
  logic [7:0] exp8 [3] = '{8'h00, 8'hFE, 8'h01};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    int edges;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; src_op1 = '0; src_op2 = '0;
    flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    alu_op8 = '0; a8 = '0; b8 = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst/out_valid", out_valid, 0);
    check("rst/busy", busy, 0);
    check("rst/alu_out", alu_out, 0);
    check("rst/in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    run_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    run_op(ALU_SRA, 32'h8000_0000, 32'h24);
    run_op(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_DIVU, 32'd7, 32'd0);
    run_op(ALU_REMU, 32'd7, 32'd0);
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2);
    run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd0);
    run_op(ALU_REM, 32'hFFFF_FFF9, 32'd0);
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Result held with out_ready low, then back-to-back accept
    @(negedge clk);
    alu_op = ALU_ADD; src_op1 = 32'd1; src_op2 = 32'd2;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold/valid", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold/alu_out", alu_out, 32'd3);
      check("hold/in_ready", in_ready, 0);
      check("hold/out_valid", out_valid, 1);
    end
    @(negedge clk);
    alu_op = ALU_SUB; src_op1 = 32'd10; src_op2 = 32'd3;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("b2b/in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b/out_valid", out_valid, 1);
    check("b2b/alu_out", alu_out, 32'd7);
    drain("b2b");

    // Flush in the middle of a divide
    @(negedge clk);
    alu_op = ALU_DIVU; src_op1 = 32'd100; src_op2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("flush/busy_before", busy, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/out_valid", out_valid, 0);
    check("flush/busy", busy, 0);
    check("flush/in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush/no_result", seen, 0);
    run_op(ALU_ADD, 32'd2, 32'd3);

    // Flush wins over a valid request in idle
    @(negedge clk);
    alu_op = ALU_ADD; src_op1 = 32'd4; src_op2 = 32'd4;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/out_valid", out_valid, 0);
    check("flush_idle/busy", busy, 0);

    // Flush discards a held result
    @(negedge clk);
    alu_op = ALU_XOR; src_op1 = 32'hF0; src_op2 = 32'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_done/valid_before", out_valid, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done/out_valid", out_valid, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    alu_op = ALU_MUL; src_op1 = 32'hFFFF_FFFF; src_op2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("rst_mul/busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mul/out_valid", out_valid, 0);
    check("rst_mul/busy", busy, 0);
    check("rst_mul/alu_out", alu_out, 0);
    check("rst_mul/in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      op = op_pool[$urandom_range(0, 25)];
      run_op(op, rnd_operand(), rnd_operand());
    end

    // Narrow build: 8-bit multiply corner cases, latency XLEN+1 = 9
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_op8 = ops8[i]; a8 = 8'hFF; b8 = 8'hFF;
      in_valid8 = 1'b1; out_ready8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      edges = 1;
      while (!out_valid8 && edges < 50) begin
        @(posedge clk); #1;
        edges++;
      end
      check($sformatf("x8 op%0d/latency", ops8[i]), 64'(edges), 64'd9);
      check($sformatf("x8 op%0d/result", ops8[i]), alu_out8, exp8[i]);
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check($sformatf("x8 op%0d/drained", ops8[i]), out_valid8, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
